// File: rtl/ghash_ctrl.sv
// GHASH sequencer: loads H, clears the accumulator, streams AAD and
// ciphertext blocks (zero-padding each segment's partial last block),
// issues the [len(A)||len(C)] block and presents the final tag.
module ghash_ctrl #(
   parameter int WIDTH   = 128,
   parameter int LEN_W   = 32,
   parameter int MUL_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] h_key,
   input  logic [LEN_W-1:0] aad_len,
   input  logic [LEN_W-1:0] ct_len,
   input  logic [WIDTH-1:0] blk_data,
   input  logic             blk_valid,
   output logic             blk_ready,
   output logic             busy,
   output logic [WIDTH-1:0] h_reg_data,
   output logic             h_reg_en,
   output logic [WIDTH-1:0] aad_data,
   output logic [WIDTH-1:0] cipher_text,
   output logic [WIDTH-1:0] length_data,
   output logic [1:0]       mux_sel,
   output logic             ac_reg_en,
   output logic             ac_clr,
   output logic             s_reg_en,
   input  logic [WIDTH-1:0] s_reg_out,
   output logic [WIDTH-1:0] tag,
   output logic             tag_valid
);

   localparam int CNT_W = LEN_W - 3;
   localparam int WAIT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MUL_LAT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_H, S_CLR, S_AAD, S_AAD_WAIT,
      S_CT, S_CT_WAIT, S_LEN, S_LEN_WAIT, S_DONE
   } state_t;

   state_t state, next_state;

   logic [WIDTH-1:0]  h_q, tag_q;
   logic [LEN_W-1:0]  aad_len_q, ct_len_q;
   logic [CNT_W-1:0]  aad_rem, ct_rem;
   logic [CNT_W-1:0]  aad_blks, ct_blks;
   logic [WAIT_W-1:0] wait_cnt;
   logic              aad_fire, ct_fire, aad_last, ct_last;
   logic [WIDTH-1:0]  aad_mask, ct_mask;
   logic [63:0]       aad_bits, ct_bits;

   // Keeps the first r bytes of a block (byte 0 is the MSB); r = 0 keeps all
   function automatic logic [WIDTH-1:0] tail_mask(input logic [3:0] r);
      logic [WIDTH-1:0] ones;
      ones = '1;
      if (r == 4'd0) return ones;
      return ~(ones >> {r, 3'b000});
   endfunction

   assign aad_blks = CNT_W'(aad_len[LEN_W-1:4]) + CNT_W'(|aad_len[3:0]);
   assign ct_blks  = CNT_W'(ct_len[LEN_W-1:4]) + CNT_W'(|ct_len[3:0]);
   assign aad_fire = (state == S_AAD) && blk_valid;
   assign ct_fire  = (state == S_CT) && blk_valid;
   assign aad_last = (aad_rem == CNT_ONE);
   assign ct_last  = (ct_rem == CNT_ONE);
   assign aad_mask = tail_mask(aad_len_q[3:0]);
   assign ct_mask  = tail_mask(ct_len_q[3:0]);
   assign aad_bits = 64'(aad_len_q) << 3;
   assign ct_bits  = 64'(ct_len_q) << 3;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Message parameters, remaining block counts, wait timer and held tag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_q       <= '0;
         tag_q     <= '0;
         aad_len_q <= '0;
         ct_len_q  <= '0;
         aad_rem   <= '0;
         ct_rem    <= '0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  h_q       <= h_key;
                  aad_len_q <= aad_len;
                  ct_len_q  <= ct_len;
                  aad_rem   <= aad_blks;
                  ct_rem    <= ct_blks;
               end
            end
            S_AAD: begin
               if (aad_fire) begin
                  aad_rem  <= aad_rem - CNT_ONE;
                  wait_cnt <= WAIT_LOAD;
               end
            end
            S_CT: begin
               if (ct_fire) begin
                  ct_rem   <= ct_rem - CNT_ONE;
                  wait_cnt <= WAIT_LOAD;
               end
            end
            S_LEN:                              wait_cnt <= WAIT_LOAD;
            S_AAD_WAIT, S_CT_WAIT, S_LEN_WAIT:  wait_cnt <= wait_cnt - WAIT_ONE;
            S_DONE:                             tag_q <= s_reg_out;
            default: ;
         endcase
      end
   end

   // Next-state logic; the WAIT states cover the multiplier's extra cycles
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (start) next_state = S_LOAD_H;
         S_LOAD_H: next_state = S_CLR;
         S_CLR: begin
            if (aad_rem != '0)     next_state = S_AAD;
            else if (ct_rem != '0) next_state = S_CT;
            else                   next_state = S_LEN;
         end
         S_AAD: begin
            if (aad_fire) begin
               if (MUL_LAT > 1)        next_state = S_AAD_WAIT;
               else if (!aad_last)     next_state = S_AAD;
               else if (ct_rem != '0)  next_state = S_CT;
               else                    next_state = S_LEN;
            end
         end
         S_AAD_WAIT: begin
            if (wait_cnt == WAIT_ONE) begin
               if (aad_rem != '0)     next_state = S_AAD;
               else if (ct_rem != '0) next_state = S_CT;
               else                   next_state = S_LEN;
            end
         end
         S_CT: begin
            if (ct_fire) begin
               if (MUL_LAT > 1)    next_state = S_CT_WAIT;
               else if (!ct_last)  next_state = S_CT;
               else                next_state = S_LEN;
            end
         end
         S_CT_WAIT: begin
            if (wait_cnt == WAIT_ONE)
               next_state = (ct_rem != '0) ? S_CT : S_LEN;
         end
         S_LEN:      next_state = (MUL_LAT > 1) ? S_LEN_WAIT : S_DONE;
         S_LEN_WAIT: if (wait_cnt == WAIT_ONE) next_state = S_DONE;
         S_DONE:     next_state = S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   // Datapath controls; tag shows the fresh S value during the strobe cycle
   always_comb begin
      blk_ready   = 1'b0;
      busy        = (state != S_IDLE);
      h_reg_data  = '0;
      h_reg_en    = 1'b0;
      aad_data    = '0;
      cipher_text = '0;
      length_data = '0;
      mux_sel     = 2'b00;
      ac_reg_en   = 1'b0;
      ac_clr      = 1'b0;
      s_reg_en    = 1'b0;
      tag         = tag_q;
      tag_valid   = 1'b0;
      case (state)
         S_LOAD_H: begin
            h_reg_data = h_q;
            h_reg_en   = 1'b1;
         end
         S_CLR: ac_clr = 1'b1;
         S_AAD: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               aad_data  = aad_last ? (blk_data & aad_mask) : blk_data;
               ac_reg_en = 1'b1;
               s_reg_en  = 1'b1;
            end
         end
         S_CT: begin
            blk_ready = 1'b1;
            mux_sel   = 2'b01;
            if (blk_valid) begin
               cipher_text = ct_last ? (blk_data & ct_mask) : blk_data;
               ac_reg_en   = 1'b1;
               s_reg_en    = 1'b1;
            end
         end
         S_LEN: begin
            mux_sel     = 2'b10;
            length_data = {aad_bits, ct_bits};
            ac_reg_en   = 1'b1;
            s_reg_en    = 1'b1;
         end
         S_DONE: begin
            tag       = s_reg_out;
            tag_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Directed bench for ghash_ctrl: two instances (MUL_LAT=1 and 3), each with
// a behavioural GHASH datapath; tags compared against a software GHASH.
module tb_ghash_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         blk_valid = 1'b0;
   logic         use3 = 1'b0;
   logic [127:0] h_key = '0;
   logic [127:0] blk_data = '0;
   logic [31:0]  aad_len = '0;
   logic [31:0]  ct_len = '0;

   logic start_1, start_3;
   logic rdy_1, busy_1, hen_1, aen_1, clr_1, sen_1, tv_1;
   logic rdy_3, busy_3, hen_3, aen_3, clr_3, sen_3, tv_3;
   logic [1:0]   mux_1, mux_3;
   logic [127:0] hd_1, ad_1, cd_1, ld_1, tag_1, s_1 = '0, acc_1 = '0, hh_1 = '0;
   logic [127:0] hd_3, ad_3, cd_3, ld_3, tag_3, s_3 = '0, acc_3 = '0, hh_3 = '0;

   logic o_rdy, o_busy, o_hen, o_aen, o_clr, o_sen, o_tv;
   logic [1:0]   o_mux;
   logic [127:0] o_hd, o_ad, o_cd, o_ld, o_tag;

   typedef struct {
      int         cyc;
      logic [1:0] mux;
      logic [127:0] a;
      logic [127:0] c;
      logic [127:0] l;
   } upd_t;

   upd_t         upd_q[$];
   int           ready_q[$];
   logic [127:0] aad_q[$], ct_q[$], all_q[$];
   int           done_cycle, h_cycle, clr_cycle;
   logic [127:0] got_tag, h_seen, tag_ref;
   int           vectors = 0;
   int           miscompares = 0;

   assign start_1 = start & ~use3;
   assign start_3 = start & use3;

   ghash_ctrl #(.WIDTH(128), .LEN_W(32), .MUL_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_1), .h_key(h_key), .aad_len(aad_len),
      .ct_len(ct_len), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(rdy_1),
      .busy(busy_1), .h_reg_data(hd_1), .h_reg_en(hen_1), .aad_data(ad_1),
      .cipher_text(cd_1), .length_data(ld_1), .mux_sel(mux_1), .ac_reg_en(aen_1),
      .ac_clr(clr_1), .s_reg_en(sen_1), .s_reg_out(s_1), .tag(tag_1), .tag_valid(tv_1)
   );

   ghash_ctrl #(.WIDTH(128), .LEN_W(32), .MUL_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start_3), .h_key(h_key), .aad_len(aad_len),
      .ct_len(ct_len), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(rdy_3),
      .busy(busy_3), .h_reg_data(hd_3), .h_reg_en(hen_3), .aad_data(ad_3),
      .cipher_text(cd_3), .length_data(ld_3), .mux_sel(mux_3), .ac_reg_en(aen_3),
      .ac_clr(clr_3), .s_reg_en(sen_3), .s_reg_out(s_3), .tag(tag_3), .tag_valid(tv_3)
   );

   assign o_rdy  = use3 ? rdy_3  : rdy_1;
   assign o_busy = use3 ? busy_3 : busy_1;
   assign o_hen  = use3 ? hen_3  : hen_1;
   assign o_aen  = use3 ? aen_3  : aen_1;
   assign o_clr  = use3 ? clr_3  : clr_1;
   assign o_sen  = use3 ? sen_3  : sen_1;
   assign o_tv   = use3 ? tv_3   : tv_1;
   assign o_mux  = use3 ? mux_3  : mux_1;
   assign o_hd   = use3 ? hd_3   : hd_1;
   assign o_ad   = use3 ? ad_3   : ad_1;
   assign o_cd   = use3 ? cd_3   : cd_1;
   assign o_ld   = use3 ? ld_3   : ld_1;
   assign o_tag  = use3 ? tag_3  : tag_1;

   always #5 clk = ~clk;

   // GF(2^128) multiply in GCM bit order
   function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
      logic [127:0] z, v;
      z = '0;
      v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   function automatic logic [127:0] dp_sel(input logic [1:0] m, input logic [127:0] a,
                                           input logic [127:0] c, input logic [127:0] l);
      if (m == 2'b00) return a;
      if (m == 2'b01) return c;
      return l;
   endfunction

   // Zero every byte from index r onward; r = 0 keeps the whole block
   function automatic logic [127:0] keep_bytes(input logic [127:0] b, input int r);
      logic [127:0] t;
      t = b;
      if (r != 0)
         for (int k = 0; k < 16; k++)
            if (k >= r) t[127-8*k -: 8] = 8'h00;
      return t;
   endfunction

   // Reference GHASH over the raw blocks held in aad_q and ct_q
   function automatic logic [127:0] ghash_sw(input logic [127:0] h, input int alen, input int clen);
      logic [127:0] y, b;
      y = '0;
      for (int i = 0; i < aad_q.size(); i++) begin
         b = (i == aad_q.size() - 1) ? keep_bytes(aad_q[i], alen % 16) : aad_q[i];
         y = gf_mul(y ^ b, h);
      end
      for (int i = 0; i < ct_q.size(); i++) begin
         b = (i == ct_q.size() - 1) ? keep_bytes(ct_q[i], clen % 16) : ct_q[i];
         y = gf_mul(y ^ b, h);
      end
      b = {64'(alen) * 64'd8, 64'(clen) * 64'd8};
      return gf_mul(y ^ b, h);
   endfunction

   function automatic upd_t get_upd(input int k);
      upd_t u;
      u.cyc = -1; u.mux = 2'b11; u.a = '0; u.c = '0; u.l = '0;
      if (k < upd_q.size()) u = upd_q[k];
      return u;
   endfunction

   function automatic logic [127:0] rand_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Datapath stand-in for the MUL_LAT=1 instance
   always @(posedge clk) begin
      if (hen_1) hh_1 <= hd_1;
      if (clr_1) acc_1 <= '0;
      else if (aen_1) acc_1 <= gf_mul(acc_1 ^ dp_sel(mux_1, ad_1, cd_1, ld_1), hh_1);
      if (sen_1) s_1 <= gf_mul(acc_1 ^ dp_sel(mux_1, ad_1, cd_1, ld_1), hh_1);
   end

   // Datapath stand-in for the MUL_LAT=3 instance
   always @(posedge clk) begin
      if (hen_3) hh_3 <= hd_3;
      if (clr_3) acc_3 <= '0;
      else if (aen_3) acc_3 <= gf_mul(acc_3 ^ dp_sel(mux_3, ad_3, cd_3, ld_3), hh_3);
      if (sen_3) s_3 <= gf_mul(acc_3 ^ dp_sel(mux_3, ad_3, cd_3, ld_3), hh_3);
   end

   task automatic check_output(input string name, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, "_ctrl"},
                   {o_rdy, o_busy, o_hen, o_aen, o_clr, o_sen, o_tv, o_mux}, '0);
      check_output({name, "_data"}, o_hd | o_ad | o_cd | o_ld | o_tag, '0);
   endtask

   task automatic set_blocks(input int na, input int nc);
      all_q.delete();
      for (int i = 0; i < na; i++) all_q.push_back(aad_q[i]);
      for (int i = 0; i < nc; i++) all_q.push_back(ct_q[i]);
   endtask

   // Runs one message; cycle 1 is the LOAD_H cycle after the start edge.
   // mode 0 holds blk_valid high, mode 1 toggles it randomly.
   task automatic apply_stimulus(input logic [127:0] h, input int alen, input int clen,
                                 input int mode, input bit poke, input bit abort_ct);
      int idx, cyc, tv;
      bit fin;
      idx = 0; fin = 1'b0;
      upd_q.delete(); ready_q.delete();
      done_cycle = -1; h_cycle = -1; clr_cycle = -1; h_seen = '0; got_tag = 'x;
      set_blocks(aad_q.size(), ct_q.size());
      @(posedge clk); #1;
      h_key = h; aad_len = 32'(alen); ct_len = 32'(clen); start = 1'b1; blk_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      while (!fin && cyc < 100) begin
         blk_data  = (idx < all_q.size()) ? all_q[idx] : rand_blk();
         blk_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (poke) start = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (o_rdy) ready_q.push_back(cyc);
         if (o_rdy && blk_valid) idx++;
         if (o_hen) begin h_cycle = cyc; h_seen = o_hd; end
         if (o_clr) clr_cycle = cyc;
         if (o_aen) begin
            upd_t u;
            u.cyc = cyc; u.mux = o_mux; u.a = o_ad; u.c = o_cd; u.l = o_ld;
            upd_q.push_back(u);
         end
         if (o_tv) begin done_cycle = cyc; got_tag = o_tag; fin = 1'b1; end
         if (abort_ct && o_aen && o_mux == 2'b01) begin
            #2 rst = 1'b0;
            #1 check_all_zero("rst_in_ct");
            tv = 0;
            repeat (3) begin @(negedge clk); tv += int'(o_tv); end
            rst = 1'b1;
            repeat (4) begin @(negedge clk); tv += int'(o_tv); end
            check_output("rst_no_tag_valid", tv, 0);
            fin = 1'b1;
         end
         if (!fin) begin @(posedge clk); #1; cyc++; end
      end
      start = 1'b0;
      blk_valid = 1'b0;
   endtask

   initial begin
      logic [127:0] h1, tag_a;
      upd_t u;

      #1 rst = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk); rst = 1'b1;

      // Directed message: one AAD block, one CT block
      h1 = 128'h0F0E0D0C0B0A09080706050403020100;
      aad_q.delete(); ct_q.delete();
      aad_q.push_back(128'h11112222333344445555666677778888);
      ct_q.push_back(128'hAAAABBBBCCCCDDDDEEEEFFFF00001111);
      apply_stimulus(h1, 16, 16, 0, 1'b0, 1'b0);
      check_output("t1_h_cycle", h_cycle, 1);
      check_output("t1_h_data", h_seen, h1);
      check_output("t1_clr_cycle", clr_cycle, 2);
      check_output("t1_updates", upd_q.size(), 3);
      u = get_upd(0); check_output("t1_aad", {u.cyc, u.mux, u.a}, {32'd3, 2'b00, 128'h11112222333344445555666677778888});
      u = get_upd(1); check_output("t1_ct", {u.cyc, u.mux, u.c}, {32'd4, 2'b01, 128'hAAAABBBBCCCCDDDDEEEEFFFF00001111});
      u = get_upd(2); check_output("t1_len", {u.cyc, u.mux, u.l}, {32'd5, 2'b10, 64'd128, 64'd128});
      check_output("t1_done_cycle", done_cycle, 6);
      check_output("t1_tag", got_tag, ghash_sw(h1, 16, 16));
      @(posedge clk); #1;
      check_output("t1_tag_held", {o_tag, o_busy}, {ghash_sw(h1, 16, 16), 1'b0});

      // Partial AAD tail, no ciphertext
      aad_q.delete(); ct_q.delete();
      aad_q.push_back('1); aad_q.push_back('1);
      apply_stimulus(h1, 20, 0, 0, 1'b0, 1'b0);
      check_output("t2_updates", upd_q.size(), 3);
      u = get_upd(0); check_output("t2_aad0", {u.mux, u.a}, {2'b00, {128{1'b1}}});
      u = get_upd(1); check_output("t2_aad1_masked", {u.mux, u.a}, {2'b00, 32'hFFFFFFFF, 96'h0});
      u = get_upd(2); check_output("t2_len", {u.cyc, u.mux, u.l}, {32'd5, 2'b10, 64'd160, 64'd0});
      check_output("t2_done_cycle", done_cycle, 6);
      check_output("t2_tag", got_tag, ghash_sw(h1, 20, 0));

      // Empty message with junk blocks offered throughout
      aad_q.delete(); ct_q.delete();
      apply_stimulus(h1, 0, 0, 0, 1'b0, 1'b0);
      check_output("t3_updates", upd_q.size(), 1);
      u = get_upd(0); check_output("t3_len", {u.cyc, u.mux, u.l}, {32'd3, 2'b10, 128'h0});
      check_output("t3_done_cycle", done_cycle, 4);
      check_output("t3_tag", got_tag, 128'h0);

      // Three-cycle multiplier: blk_ready pulses every third cycle
      use3 = 1'b1;
      aad_q.delete(); ct_q.delete();
      aad_q.push_back(rand_blk()); aad_q.push_back(rand_blk());
      apply_stimulus(h1, 32, 0, 0, 1'b0, 1'b0);
      check_output("t4_ready_count", ready_q.size(), 2);
      check_output("t4_ready_cycles", {ready_q.size() > 1 ? ready_q[0] : -1, ready_q.size() > 1 ? ready_q[1] : -1}, {32'd3, 32'd6});
      check_output("t4_updates", upd_q.size(), 3);
      u = get_upd(2); check_output("t4_len", {u.cyc, u.mux, u.l}, {32'd9, 2'b10, 64'd256, 64'd0});
      check_output("t4_done_cycle", done_cycle, 12);
      check_output("t4_tag", got_tag, ghash_sw(h1, 32, 0));
      use3 = 1'b0;

      // Random valid gaps and stray start pulses leave the tag unchanged
      aad_q.delete(); ct_q.delete();
      aad_q.push_back(rand_blk()); aad_q.push_back(rand_blk());
      ct_q.push_back(rand_blk()); ct_q.push_back(rand_blk()); ct_q.push_back(rand_blk());
      h1 = rand_blk();
      tag_ref = ghash_sw(h1, 20, 40);
      apply_stimulus(h1, 20, 40, 0, 1'b0, 1'b0);
      tag_a = got_tag;
      check_output("t5_nostall_done_cycle", done_cycle, 9);
      check_output("t5_nostall_tag", tag_a, tag_ref);
      apply_stimulus(h1, 20, 40, 1, 1'b1, 1'b0);
      check_output("t5_stall_updates", upd_q.size(), 6);
      check_output("t5_stall_tag", got_tag, tag_ref);

      // Reset in the CT phase aborts, then a clean message still works
      aad_q.delete(); ct_q.delete();
      aad_q.push_back(rand_blk());
      ct_q.push_back(rand_blk()); ct_q.push_back(rand_blk());
      apply_stimulus(h1, 16, 32, 0, 1'b0, 1'b1);
      apply_stimulus(h1, 16, 32, 0, 1'b0, 1'b0);
      check_output("t6_done_cycle", done_cycle, 7);
      check_output("t6_tag", got_tag, ghash_sw(h1, 16, 32));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
